fence_ctrl: RTL and testbench
=============================

// Module: fence_ctrl
// PURPOSE
//  Sequences RV32I FENCE and Zifencei FENCE.I after decode. Holds younger issue,
//  drains outstanding memory ops and the store buffer, optionally invalidates the
//  I-cache and redirects fetch, then signals completion. Sits between decode and
//  the LSU/fetch front end. Adds pred/succ filtering and a tracked outstanding count.
// PARAMETERS
//  MAX_OUTSTANDING  8  max in-flight LSU ops; CNT_W = $clog2(MAX_OUTSTANDING+1)
//  ENABLE_FENCE_I   1  0: fk_fence_i is treated as illegal
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous active-low reset
//  req_valid       in   1      decoder presents a fence
//  req_ready       out  1      accepts request (IDLE only)
//  req_kind        in   fence_kind_t  fk_fence / fk_fence_i / fk_invalid
//  req_pred        in   4      predecessor set {I,O,R,W}
//  req_succ        in   4      successor set {I,O,R,W}
//  mem_issue       in   1      LSU issued one memory op this cycle
//  mem_complete    in   1      LSU retired one memory op this cycle
//  sb_drain_req    out  1      force store-buffer drain
//  sb_empty        in   1      store buffer empty
//  icache_inv_req  out  1      I-cache invalidate request (level, held to ack)
//  icache_inv_ack  in   1      invalidate finished (1-cycle pulse)
//  stall           out  1      block issue of younger instructions
//  flush_fetch     out  1      1-cycle pulse: refetch from fence PC+4
//  done            out  1      1-cycle pulse: fence retired
//  illegal         out  1      1-cycle pulse: illegal fence request
//  outstanding     out  CNT_W  current in-flight memory ops
//  cnt_err         out  1      sticky: counter overflow/underflow seen
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, outstanding=0, cnt_err=0; all outputs 0
//   except req_ready=1 after reset release. Reset mid-operation aborts silently.
//  States: IDLE, DRAIN, INV, FLUSH, RESP. Handshake = req_valid & req_ready.
//  IDLE: req_ready=1, stall=0. On handshake (latched kind/pred/succ):
//   fk_invalid, or fk_fence_i with ENABLE_FENCE_I=0 -> illegal=1 next cycle, stay IDLE.
//   fk_fence with pred==0 or succ==0 -> RESP (no ordering needed).
//   otherwise -> DRAIN.
//  DRAIN: stall=1, sb_drain_req=1, req_ready=0. Exit when outstanding==0 and
//   sb_empty, evaluated on registered count: fk_fence -> RESP, fk_fence_i -> INV.
//  INV: stall=1, icache_inv_req=1 until icache_inv_ack sampled -> FLUSH.
//   Ack arriving in same cycle as entry is honoured.
//  FLUSH: stall=1, flush_fetch=1 one cycle -> RESP.
//  RESP: stall=1, done=1 one cycle -> IDLE. Min latency handshake->done: 1 cycle
//   (null fence), 2 cycles (empty drain), FENCE.I with 0-cycle ack: 4 cycles.
//  Counter: +1 on mem_issue, -1 on mem_complete, both -> unchanged; independent
//   of state. Issue at MAX_OUTSTANDING saturates and sets cnt_err; complete at
//   0 holds 0 and sets cnt_err. cnt_err clears only on reset.
//  mem_issue during DRAIN is counted (no assumption that stall is instant).
//  New req_valid while not IDLE is ignored (req_ready=0); decoder must hold it.
// STRUCTURE
//  instr_type package: add fence_state_t enum; FB_I=3, FB_O=2, FB_R=1, FB_W=0
//   bit-index constants. fence_kind_t already lives there.
//  Sub-module: mem_outstanding_cnt (MAX_OUTSTANDING) owns counter + cnt_err.
//  decode_fence stays the combinational funct3 classifier feeding req_kind.
// TESTING
//  rst low mid-DRAIN with outstanding=3 -> next edge: IDLE, outstanding=0, all out 0.
//  fk_fence pred=4'b0011 succ=0 -> done pulse next cycle, no stall on entry cycle+1 after.
//  3 issues then fk_fence pred=succ=4'b1111, completes at +2,+5,+9 -> done 1 cycle after 3rd.
//  fk_fence_i, sb_empty=1, ack 4 cycles after req -> inv_req 4 cycles, flush_fetch, done.
//  ENABLE_FENCE_I=0, fk_fence_i -> illegal pulse, state stays IDLE, stall=0.
//  mem_complete at outstanding=0; 9 issues with MAX=8 -> count 0 / 8, cnt_err=1 sticky.

Source files
------------

// File: rtl/instr_type_pkg.sv
// Shared instruction-type definitions for the fence path: request kinds,
// sequencer states and predecessor/successor bit positions.
package instr_type;

  typedef enum logic [1:0] {
    fk_fence   = 2'd0,
    fk_fence_i = 2'd1,
    fk_invalid = 2'd2
  } fence_kind_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_INV,
    S_FLUSH,
    S_RESP
  } fence_state_t;

  localparam int unsigned FB_I = 3;
  localparam int unsigned FB_O = 2;
  localparam int unsigned FB_R = 1;
  localparam int unsigned FB_W = 0;

  // A FENCE only orders anything when both the pred and succ sets are non-empty.
  function automatic logic fence_orders(input logic [3:0] pred, input logic [3:0] succ);
    return (pred != '0) && (succ != '0);
  endfunction

endpackage

// File: rtl/fence_ctrl_cnt.sv
// Tracks in-flight LSU memory ops; saturates at both ends and records any
// overflow/underflow in a sticky error flag.
module mem_outstanding_cnt #(
  parameter  int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             complete,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      err   <= 1'b0;
    end else if (issue && !complete) begin
      if (count == CNT_W'(MAX_OUTSTANDING)) err <= 1'b1;
      else count <= count + CNT_W'(1);
    end else if (complete && !issue) begin
      if (count == '0) err <= 1'b1;
      else count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fence_ctrl.sv
// FENCE / FENCE.I sequencer: stalls younger issue, drains memory ops and the
// store buffer, optionally invalidates the I-cache and redirects fetch.
module fence_ctrl
  import instr_type::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 8,
  parameter  bit          ENABLE_FENCE_I  = 1'b1,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  fence_kind_t      req_kind,
  input  logic [3:0]       req_pred,
  input  logic [3:0]       req_succ,
  input  logic             mem_issue,
  input  logic             mem_complete,
  output logic             sb_drain_req,
  input  logic             sb_empty,
  output logic             icache_inv_req,
  input  logic             icache_inv_ack,
  output logic             stall,
  output logic             flush_fetch,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] outstanding,
  output logic             cnt_err
);

  fence_state_t state;
  logic         is_fence_i;

  mem_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .issue    (mem_issue),
    .complete (mem_complete),
    .count    (outstanding),
    .err      (cnt_err)
  );

  // req_ready comes out of reset low and rises on the first clock in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      is_fence_i     <= 1'b0;
      req_ready      <= 1'b0;
      stall          <= 1'b0;
      sb_drain_req   <= 1'b0;
      icache_inv_req <= 1'b0;
      flush_fetch    <= 1'b0;
      done           <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      flush_fetch <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            is_fence_i <= (req_kind == fk_fence_i);
            case (req_kind)
              fk_fence: begin
                req_ready <= 1'b0;
                stall     <= 1'b1;
                if (fence_orders(req_pred, req_succ)) begin
                  state        <= S_DRAIN;
                  sb_drain_req <= 1'b1;
                end else begin
                  state <= S_RESP;
                  done  <= 1'b1;
                end
              end
              fk_fence_i: begin
                if (ENABLE_FENCE_I) begin
                  state        <= S_DRAIN;
                  req_ready    <= 1'b0;
                  stall        <= 1'b1;
                  sb_drain_req <= 1'b1;
                end else begin
                  illegal <= 1'b1;
                end
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        S_DRAIN: begin
          if (outstanding == '0 && sb_empty) begin
            sb_drain_req <= 1'b0;
            if (is_fence_i) begin
              state          <= S_INV;
              icache_inv_req <= 1'b1;
            end else begin
              state <= S_RESP;
              done  <= 1'b1;
            end
          end
        end
        S_INV: begin
          if (icache_inv_ack) begin
            state          <= S_FLUSH;
            icache_inv_req <= 1'b0;
            flush_fetch    <= 1'b1;
          end
        end
        S_FLUSH: begin
          state <= S_RESP;
          done  <= 1'b1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          stall     <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          stall     <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fence_ctrl.sv
// Directed bench for fence_ctrl: per-cycle vector table plus hand sequences
// for drain timing, FENCE.I invalidate, reset abort and counter saturation.
module tb_fence_ctrl;
  import instr_type::*;

  logic        clk, rst;
  logic        req_valid, mem_issue, mem_complete, sb_empty, icache_inv_ack;
  fence_kind_t req_kind;
  logic [3:0]  req_pred, req_succ;

  logic       rdy0, drn0, inv0, stl0, fl0, dn0, ill0, err0;
  logic [3:0] out0;
  logic       rdy1, drn1, inv1, stl1, fl1, dn1, ill1, err1;
  logic [3:0] out1;

  int n_chk = 0;
  int n_fail = 0;

  fence_ctrl #(.MAX_OUTSTANDING(8), .ENABLE_FENCE_I(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
    .req_kind(req_kind), .req_pred(req_pred), .req_succ(req_succ),
    .mem_issue(mem_issue), .mem_complete(mem_complete),
    .sb_drain_req(drn0), .sb_empty(sb_empty),
    .icache_inv_req(inv0), .icache_inv_ack(icache_inv_ack),
    .stall(stl0), .flush_fetch(fl0), .done(dn0), .illegal(ill0),
    .outstanding(out0), .cnt_err(err0)
  );

  fence_ctrl #(.MAX_OUTSTANDING(8), .ENABLE_FENCE_I(1'b0)) dut_nofi (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_kind(req_kind), .req_pred(req_pred), .req_succ(req_succ),
    .mem_issue(mem_issue), .mem_complete(mem_complete),
    .sb_drain_req(drn1), .sb_empty(sb_empty),
    .icache_inv_req(inv1), .icache_inv_ack(icache_inv_ack),
    .stall(stl1), .flush_fetch(fl1), .done(dn1), .illegal(ill1),
    .outstanding(out1), .cnt_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags order: {req_ready, stall, sb_drain_req, icache_inv_req, flush_fetch, done, illegal}
  typedef struct {
    logic        v;
    fence_kind_t k;
    logic [3:0]  p, s;
    logic        is, co, sbe, ack;
    logic [6:0]  f;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic v, fence_kind_t k, logic [3:0] p, logic [3:0] s,
                              logic is, logic co, logic sbe, logic ack,
                              logic [6:0] f, int cnt, logic err);
    vec_t r;
    r.v = v; r.k = k; r.p = p; r.s = s; r.is = is; r.co = co; r.sbe = sbe;
    r.ack = ack; r.f = f; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  function automatic logic [6:0] flags0();
    return {rdy0, stl0, drn0, inv0, fl0, dn0, ill0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_kind = fk_fence; req_pred = '0; req_succ = '0;
    mem_issue = 1'b0; mem_complete = 1'b0; sb_empty = 1'b1; icache_inv_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int inv_cycles;
    int cnt;
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    chk("reset_flags", int'(flags0()), 0);
    chk("reset_outstanding", int'(out0), 0);
    chk("reset_cnt_err", int'(err0), 0);
    rst = 1'b1;

    tbl[0]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);
    tbl[1]  = mk(1, fk_fence,   4'h3, 4'h0, 0, 0, 1, 0, 7'b0100010, 0, 0);
    tbl[2]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);
    tbl[3]  = mk(1, fk_fence,   4'hF, 4'hF, 0, 0, 1, 0, 7'b0110000, 0, 0);
    tbl[4]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b0100010, 0, 0);
    tbl[5]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);
    tbl[6]  = mk(1, fk_invalid, 4'hF, 4'hF, 0, 0, 1, 0, 7'b1000001, 0, 0);
    tbl[7]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);
    tbl[8]  = mk(1, fk_fence_i, 4'h0, 4'h0, 0, 0, 1, 0, 7'b0110000, 0, 0);
    tbl[9]  = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b0101000, 0, 0);
    tbl[10] = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 1, 7'b0100100, 0, 0);
    tbl[11] = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b0100010, 0, 0);
    tbl[12] = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);
    tbl[13] = mk(0, fk_fence,   4'h0, 4'h0, 1, 0, 1, 0, 7'b1000000, 1, 0);
    tbl[14] = mk(0, fk_fence,   4'h0, 4'h0, 1, 1, 1, 0, 7'b1000000, 1, 0);
    tbl[15] = mk(1, fk_fence,   4'hF, 4'hF, 0, 0, 0, 0, 7'b0110000, 1, 0);
    tbl[16] = mk(0, fk_fence,   4'h0, 4'h0, 0, 1, 0, 0, 7'b0110000, 0, 0);
    tbl[17] = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 0, 0, 7'b0110000, 0, 0);
    tbl[18] = mk(1, fk_fence,   4'hF, 4'hF, 0, 0, 1, 0, 7'b0100010, 0, 0);
    tbl[19] = mk(0, fk_fence,   4'h0, 4'h0, 0, 0, 1, 0, 7'b1000000, 0, 0);

    for (int i = 0; i < 20; i++) begin
      req_valid = tbl[i].v; req_kind = tbl[i].k; req_pred = tbl[i].p; req_succ = tbl[i].s;
      mem_issue = tbl[i].is; mem_complete = tbl[i].co; sb_empty = tbl[i].sbe;
      icache_inv_ack = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_flags", i), int'(flags0()), int'(tbl[i].f));
      chk($sformatf("vec%0d_outstanding", i), int'(out0), tbl[i].cnt);
      chk($sformatf("vec%0d_cnt_err", i), int'(err0), int'(tbl[i].err));
    end
    idle_inputs();

    // Drain with three ops in flight, completions at +2, +5, +9.
    mem_issue = 1'b1;
    repeat (3) step();
    mem_issue = 1'b0;
    chk("drain3_preload", int'(out0), 3);
    req_valid = 1'b1; req_kind = fk_fence; req_pred = 4'hF; req_succ = 4'hF;
    step();
    req_valid = 1'b0;
    chk("drain3_entry_stall", int'(stl0), 1);
    chk("drain3_entry_sbreq", int'(drn0), 1);
    cnt = 3;
    for (int i = 1; i <= 12; i++) begin
      mem_complete = (i == 2 || i == 5 || i == 9);
      step();
      if (mem_complete) cnt--;
      chk($sformatf("drain3_c%0d_outstanding", i), int'(out0), cnt);
      chk($sformatf("drain3_c%0d_done", i), int'(dn0), int'(i == 10));
      chk($sformatf("drain3_c%0d_stall", i), int'(stl0), int'(i <= 10));
    end
    mem_complete = 1'b0;

    // FENCE.I with the invalidate ack held back so inv_req stays up four cycles.
    req_valid = 1'b1; req_kind = fk_fence_i; req_pred = '0; req_succ = '0;
    step();
    req_valid = 1'b0;
    inv_cycles = 0;
    for (int i = 1; i <= 7; i++) begin
      icache_inv_ack = (i == 5);
      step();
      if (inv0) inv_cycles++;
      chk($sformatf("fencei_c%0d_inv", i), int'(inv0), int'(i >= 1 && i <= 4));
      chk($sformatf("fencei_c%0d_flush", i), int'(fl0), int'(i == 5));
      chk($sformatf("fencei_c%0d_done", i), int'(dn0), int'(i == 6));
    end
    icache_inv_ack = 1'b0;
    chk("fencei_inv_cycles", inv_cycles, 4);
    chk("fencei_back_idle", int'(rdy0), 1);

    // FENCE.I disabled: illegal pulse, no stall, stays ready.
    req_valid = 1'b1; req_kind = fk_fence_i;
    step();
    req_valid = 1'b0;
    chk("nofi_illegal", int'(ill1), 1);
    chk("nofi_stall", int'(stl1), 0);
    chk("nofi_ready", int'(rdy1), 1);
    step();
    chk("nofi_illegal_pulse_end", int'(ill1), 0);
    chk("nofi_stall_after", int'(stl1), 0);
    chk("nofi_ready_after", int'(rdy1), 1);
    do_reset();

    // Reset abort in the middle of a drain with three ops outstanding.
    mem_issue = 1'b1;
    repeat (3) step();
    mem_issue = 1'b0;
    req_valid = 1'b1; req_kind = fk_fence; req_pred = 4'hF; req_succ = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    chk("abort_pre_flags", int'(flags0()), int'(7'b0110000));
    chk("abort_pre_outstanding", int'(out0), 3);
    rst = 1'b0;
    #1;
    chk("abort_async_outstanding", int'(out0), 0);
    step();
    chk("abort_flags", int'(flags0()), 0);
    chk("abort_outstanding", int'(out0), 0);
    rst = 1'b1;
    step();
    chk("abort_release_flags", int'(flags0()), int'(7'b1000000));

    // Counter underflow, then overflow at MAX_OUTSTANDING=8.
    mem_complete = 1'b1;
    step();
    mem_complete = 1'b0;
    chk("underflow_count", int'(out0), 0);
    chk("underflow_err", int'(err0), 1);
    step();
    chk("underflow_err_sticky", int'(err0), 1);
    do_reset();
    chk("err_cleared_by_reset", int'(err0), 0);
    mem_issue = 1'b1;
    repeat (8) step();
    chk("full_count", int'(out0), 8);
    chk("full_no_err", int'(err0), 0);
    step();
    mem_issue = 1'b0;
    chk("overflow_count", int'(out0), 8);
    chk("overflow_err", int'(err0), 1);
    mem_complete = 1'b1;
    step();
    mem_complete = 1'b0;
    chk("after_overflow_count", int'(out0), 7);
    chk("after_overflow_err", int'(err0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
